// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM port arbiter.
//   - arb_state_t : arbiter FSM states
//   - SZ_*        : access-size codes understood by the RAM controller
//   - port_id_t   : identifies one of the two requesters
//   - is_half_code/is_byte_code : size-code classification helpers
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } arb_state_t;

    localparam logic [2:0] SZ_B  = 3'b001;  // byte, sign-extended
    localparam logic [2:0] SZ_H  = 3'b010;  // half, sign-extended
    localparam logic [2:0] SZ_BU = 3'b101;  // byte, zero-extended
    localparam logic [2:0] SZ_HU = 3'b110;  // half, zero-extended

    typedef logic port_id_t;
    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    function automatic logic is_half_code(input logic [2:0] code);
        return (code == SZ_H) || (code == SZ_HU);
    endfunction

    function automatic logic is_byte_code(input logic [2:0] code);
        return (code == SZ_B) || (code == SZ_BU);
    endfunction

endpackage

// File: rtl/ram_arb_align_chk.sv
// ram_arb_align_chk: combinational alignment checker.
//   i_ctrl    : access-size code of the access being served
//   i_addr_lo : address bits [1:0] of that access
//   o_err     : 1 when a half access is odd or a word access is not 4-aligned
// Any code that is neither byte nor half is treated as a word access.
import ram_arb_pkg::*;

module ram_arb_align_chk (
    input  logic [2:0] i_ctrl,
    input  logic [1:0] i_addr_lo,
    output logic       o_err
);

    logic w_half;
    logic w_word;

    assign w_half = is_half_code(i_ctrl);
    assign w_word = !w_half && !is_byte_code(i_ctrl);
    assign o_err  = (w_half && i_addr_lo[0]) || (w_word && (i_addr_lo != 2'b00));

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM-controller port between P0 (CPU load/store
// unit) and P1 (debug/program loader) with round-robin fairness.
//   clk, reset                : clock, synchronous active-high reset
//   p0_* / p1_* (inputs)      : req, we, addr, wData, ctrl of each requester
//   p0_* / p1_* (outputs)     : one-cycle ack, rData (valid with ack on reads), err
//   ram_we/addr/wData/ctrl    : towards the RAM controller
//   ram_rData                 : combinational read data from the RAM controller
// Optional: define RAM_ARB_ALIGN_CHECK_EN to reject misaligned half/word
// accesses with ack+err and no write; otherwise they pass through.
import ram_arb_pkg::*;

module ram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wData,
    input  logic [CTRL_W-1:0] p0_ctrl,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rData,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wData,
    input  logic [CTRL_W-1:0] p1_ctrl,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rData,
    output logic              p1_err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wData,
    output logic [CTRL_W-1:0] ram_ctrl,
    input  logic [DATA_W-1:0] ram_rData
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    port_id_t   r_last_srv;
    logic       w_err_cond;

`ifdef RAM_ARB_ALIGN_CHECK_EN
    logic [CTRL_W-1:0] w_sel_ctrl;
    logic [1:0]        w_sel_addr_lo;

    assign w_sel_ctrl    = (r_state == SERVE1) ? p1_ctrl : p0_ctrl;
    assign w_sel_addr_lo = (r_state == SERVE1) ? p1_addr[1:0] : p0_addr[1:0];

    ram_arb_align_chk u_align_chk (
        .i_ctrl    (w_sel_ctrl),
        .i_addr_lo (w_sel_addr_lo),
        .o_err     (w_err_cond)
    );
`else
    assign w_err_cond = 1'b0;
`endif

    // State register and round-robin history; a serve cycle always records its port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last_srv <= PORT1;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == SERVE0) begin
                r_last_srv <= PORT0;
            end else if (r_state == SERVE1) begin
                r_last_srv <= PORT1;
            end else begin
                r_last_srv <= r_last_srv;
            end
        end
    end

    // Next-state selection and the served port's RAM/handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        ram_we      = 1'b0;
        ram_addr    = {ADDR_W{1'b0}};
        ram_wData   = {DATA_W{1'b0}};
        ram_ctrl    = {CTRL_W{1'b0}};
        p0_ack      = 1'b0;
        p0_err      = 1'b0;
        p0_rData    = {DATA_W{1'b0}};
        p1_ack      = 1'b0;
        p1_err      = 1'b0;
        p1_rData    = {DATA_W{1'b0}};
        case (r_state)
            IDLE: begin
                if (p0_req && p1_req) begin
                    // Tie: serve the port that was not served last.
                    w_state_nxt = (r_last_srv == PORT1) ? SERVE0 : SERVE1;
                end else if (p0_req) begin
                    w_state_nxt = SERVE0;
                end else if (p1_req) begin
                    w_state_nxt = SERVE1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SERVE0: begin
                ram_addr  = p0_addr;
                ram_wData = p0_wData;
                ram_ctrl  = p0_ctrl;
                ram_we    = p0_we && p0_req && !w_err_cond && !reset;
                p0_ack    = p0_req && !reset;
                p0_err    = p0_req && w_err_cond && !reset;
                if (p0_req && !p0_we && !w_err_cond && !reset) begin
                    p0_rData = ram_rData;
                end else begin
                    p0_rData = {DATA_W{1'b0}};
                end
                // P0's req this cycle belongs to the current transaction.
                w_state_nxt = p1_req ? SERVE1 : IDLE;
            end
            SERVE1: begin
                ram_addr  = p1_addr;
                ram_wData = p1_wData;
                ram_ctrl  = p1_ctrl;
                ram_we    = p1_we && p1_req && !w_err_cond && !reset;
                p1_ack    = p1_req && !reset;
                p1_err    = p1_req && w_err_cond && !reset;
                if (p1_req && !p1_we && !w_err_cond && !reset) begin
                    p1_rData = ram_rData;
                end else begin
                    p1_rData = {DATA_W{1'b0}};
                end
                w_state_nxt = p0_req ? SERVE0 : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one data-RAM controller port (we/addr/wData/rData/ramControl) between two requesters.
- Requester P0 is the CPU load/store unit; requester P1 is the debug/program loader.
- Sequencing is registered: the block holds the request/acknowledge handshake and round-robin fairness, and drives the RAM-controller port one requester at a time.
- Sits between the multicycle CPU datapath, the loader and the existing RAM controller.

Parameters:
- ADDR_W, 32, address width of requester and RAM ports.
- DATA_W, 32, data width.
- CTRL_W, 3, width of the access-size code (ramControl encoding).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- p0_req  input  1  P0 access request; held with its qualifiers until p0_ack.
- p0_we  input  1  P0 write (1) / read (0).
- p0_addr  input  ADDR_W  P0 byte address.
- p0_wData  input  DATA_W  P0 store data.
- p0_ctrl  input  CTRL_W  P0 size code.
- p0_ack  output  1  one-cycle completion strobe.
- p0_rData  output  DATA_W  load result, valid only while p0_ack=1.
- p0_err  output  1  alignment error, valid with p0_ack.
- p1_req, p1_we, p1_addr, p1_wData, p1_ctrl, p1_ack, p1_rData, p1_err: same as P0, for P1.
- ram_we  output  1  to RAM controller we.
- ram_addr  output  ADDR_W  to RAM controller addr.
- ram_wData  output  DATA_W  to RAM controller wData.
- ram_ctrl  output  CTRL_W  to RAM controller ramControl.
- ram_rData  input  DATA_W  from RAM controller; combinational read of ram_addr.

Behaviour:
- Size codes: 001 byte signed, 010 half signed, 101 byte unsigned, 110 half unsigned, any other code = word.
- States: IDLE, SERVE0, SERVE1. Register last_srv (1 bit).
- Reset values: state=IDLE, last_srv=1 (P0 wins the first tie), all ack/err=0, ram_we=0, ram_addr/ram_wData/ram_ctrl/p*_rData=0.
- IDLE:
  - RAM outputs are 0.
  - If only pX_req: next state is SERVEX.
  - If both: serve the port != last_srv.
  - If none: stay in IDLE.
- SERVEX:
  - The pX qualifiers are muxed combinationally to ram_addr, ram_wData and ram_ctrl.
  - ram_we = pX_we & pX_req & !err_cond & !reset. The write commits on this cycle's rising edge.
  - pX_ack = pX_req. pX_rData = ram_rData when the access is a read, else 0.
  - last_srv <= X.
- Exits from SERVEX:
  - If the other port's req=1, next state is SERVE(other), back-to-back with no idle cycle.
  - Otherwise next state is IDLE.
  - The served port's req in the SERVEX cycle belongs to the current transaction. A new request from that port is only considered from the next cycle.
- Latency:
  - Request seen in IDLE at cycle n gives ack at cycle n+1.
  - Worst case under contention is ack at n+2.
  - Sustained single-port throughput is 1 access per 2 cycles.
  - Under contention, both ports alternate and are acknowledged in alternate cycles.
- Request dropped before ack (protocol violation): SERVEX gives no ack and no write, and exits normally.
- Reset asserted mid-SERVE: the write is suppressed that cycle, no ack is issued, and the next state is IDLE.
- Non-served port outputs are always 0. At most one ack is high per cycle.

Optional Feature:
- Macro: RAM_ARB_ALIGN_CHECK_EN.
- Defined:
  - err_cond = half code (010/110) with addr[0]=1, or word code with addr[1:0]!=0.
  - On err_cond in SERVEX: pX_ack=1, pX_err=1, ram_we=0, pX_rData=0. The arbitration sequence is unchanged.
- Not defined:
  - err_cond=0 and p*_err are tied to 0.
  - Misaligned accesses pass through to the RAM unchanged.

Decomposition:
- Package ram_arb_pkg:
  - state enum {IDLE, SERVE0, SERVE1}.
  - Size-code localparams (SZ_B=3'b001, SZ_H=3'b010, SZ_BU=3'b101, SZ_HU=3'b110).
  - Port-id typedef.
- Sub-module ram_arb_align_chk: combinational, ctrl + addr[1:0] -> err_cond. Only instantiated under the macro.

Test Plan:
- Single P0 SW: addr=0x10, wData=0xDEADBEEF, ctrl=000 -> p0_ack 1 cycle later, ram_we=1 that cycle. P0 LW at 0x10 then returns p0_rData=0xDEADBEEF.
- Simultaneous first requests: P0 LW 0x10 and P1 LW 0x20 in the same cycle -> ack P0 at n+1, ack P1 at n+2, no IDLE cycle between them. Repeating both: the next tie goes to P0 (last_srv=1).
- Continuous contention for 8 accesses each -> acks alternate P0/P1 every cycle, no starvation, never two acks in one cycle.
- Reset during SERVE1 with P1 SB addr=0x21, wData=0xAA -> no write, no ack, state IDLE. A following LW 0x20 returns its pre-reset value.
- P0 drops req while in SERVE0 -> p0_ack=0, ram_we=0, next state IDLE.
- With RAM_ARB_ALIGN_CHECK_EN:
  - P1 SH at addr=0x13 -> p1_ack=1, p1_err=1, memory unchanged.
  - Without the macro, the same access writes and p1_err=0.
